// File: rtl/matriz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matriz_pkg                                                                 |
// | Shared types and helpers for the sequential scalar-by-matrix multiplier:   |
// |   state_t   : FSM state encoding (IDLE, RUN)                               |
// |   n_elem    : element count of a DIM x DIM matrix                          |
// |   beats     : clock beats needed to cover N elements at LANES per beat     |
// |   sat_trunc : reduce a full signed product to data_w bits (clamp or wrap)  |
// |               and flag whether it left the data_w signed range             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package matriz_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Result of sat_trunc. val is 64 bits wide so one function serves every
  // element width up to 32; callers keep the low data_w bits.
  typedef struct packed {
    logic [63:0] val;
    logic        ovf;
  } sat_res_t;

  function automatic int n_elem(input int dim);
    return dim * dim;
  endfunction

  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  // product must already be sign-extended to 64 bits; data_w <= 32.
  function automatic sat_res_t sat_trunc(input logic signed [63:0] product,
                                         input logic               mode,
                                         input int                 data_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sat_res_t           r;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    r.ovf = (product > max_v) || (product < min_v);
    if (mode && (product > max_v)) begin
      r.val = max_v;
    end else if (mode && (product < min_v)) begin
      r.val = min_v;
    end else begin
      // Wrap mode keeps the low bits, identical to the legacy combinational block.
      r.val = product;
    end
    return r;
  endfunction

endpackage : matriz_pkg
`default_nettype wire

// File: rtl/mult_sat_elemento.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_sat_elemento                                                          |
// | One combinational multiplier lane: signed element times signed scalar,     |
// | reduced to DATA_W bits by saturation or wrap, with an out-of-range flag.   |
// | Ports:                                                                     |
// |   elemento  in  DATA_W  signed matrix element                              |
// |   num       in  DATA_W  signed scalar                                      |
// |   sat_mode  in  1       1 = clamp, 0 = keep low DATA_W bits                |
// |   resultado out DATA_W  reduced product                                    |
// |   ovf       out 1       full product outside DATA_W signed range           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mult_sat_elemento
  import matriz_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] elemento,
  input  logic signed [DATA_W-1:0] num,
  input  logic                     sat_mode,
  output logic signed [DATA_W-1:0] resultado,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [63:0]         w_prod_ext;
  sat_res_t                   w_res;
  logic                       w_spare_unused;

  // Both operands are signed, so they are sign-extended to 2*DATA_W first.
  assign w_prod     = elemento * num;
  assign w_prod_ext = 64'(w_prod);
  assign w_res      = sat_trunc(w_prod_ext, sat_mode, DATA_W);

  assign resultado  = w_res.val[DATA_W-1:0];
  assign ovf        = w_res.ovf;

  // Upper bits of the shared 64-bit helper result carry no extra information.
  assign w_spare_unused = ^w_res.val[63:DATA_W];

endmodule : mult_sat_elemento
`default_nettype wire

// File: rtl/mult_escalar_matriz_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_escalar_matriz_seq                                                    |
// | Sequential scalar-by-matrix multiplier, LANES elements per clock, with a   |
// | start/busy/done handshake, saturating or wrapping arithmetic and a sticky  |
// | overflow flag covering the last operation.                                 |
// | Ports:                                                                     |
// |   clk, reset     in   clock, synchronous active-high reset                 |
// |   start          in   begin an operation (ignored while busy)              |
// |   matriz_A       in   N*DATA_W packed signed operand matrix                |
// |   num_inteiro    in   DATA_W signed scalar                                 |
// |   sat_mode       in   1 = saturate, 0 = wrap                               |
// |   nova_matriz_A  out  N*DATA_W result matrix, valid while busy = 0         |
// |   busy           out  operation in progress                                |
// |   done           out  one-cycle completion pulse                           |
// |   overflow       out  some product of the last operation was out of range  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mult_escalar_matriz_seq
  import matriz_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DIM    = 5,
  parameter  int LANES  = 5,
  localparam int N      = n_elem(DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N*DATA_W-1:0]   matriz_A,
  input  logic [DATA_W-1:0]     num_inteiro,
  input  logic                  sat_mode,
  output logic [N*DATA_W-1:0]   nova_matriz_A,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BEATS = beats(N, LANES);
  // Captured operand is zero-padded to a whole number of groups so every lane
  // read stays in range; padded lanes are masked off on write.
  localparam int PAD_N = BEATS * LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [PAD_N*DATA_W-1:0]   mat_q;
  logic [DATA_W-1:0]         num_q;
  logic                      sat_q;
  logic [N*DATA_W-1:0]       res_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      ovf_q;

  logic [DATA_W-1:0]         w_elem [LANES];
  logic [DATA_W-1:0]         w_res  [LANES];
  logic [LANES-1:0]          w_ovf;
  logic [LANES-1:0]          w_wr;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_elem[l] = mat_q[(int'(cnt_q) * LANES + l) * DATA_W +: DATA_W];
    // Lanes beyond the last real element in the final group write nothing.
    assign w_wr[l]   = (int'(cnt_q) * LANES + l) < N;

    mult_sat_elemento #(
      .DATA_W (DATA_W)
    ) u_lane (
      .elemento  (w_elem[l]),
      .num       (num_q),
      .sat_mode  (sat_q),
      .resultado (w_res[l]),
      .ovf       (w_ovf[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mat_q   <= '0;
      num_q   <= '0;
      sat_q   <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mat_q   <= (PAD_N * DATA_W)'(matriz_A);
            num_q   <= num_inteiro;
            sat_q   <= sat_mode;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            if (w_wr[l]) begin
              res_q[(int'(cnt_q) * LANES + l) * DATA_W +: DATA_W] <= w_res[l];
            end
          end
          ovf_q <= ovf_q | (|(w_ovf & w_wr));
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nova_matriz_A = res_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = ovf_q;

endmodule : mult_escalar_matriz_seq
`default_nettype wire

// File: doc/mult_escalar_matriz_seq.md
Name: mult_escalar_matriz_seq

Overview:
Sequential, parametrised scalar-by-matrix multiplier. It is the successor to the combinational 5x5 8-bit scalar multiplier used by the matrix coprocessor. It processes LANES elements per clock, so area can be traded against latency. It adds a start/busy/done handshake, selectable saturating or wrapping arithmetic, and a sticky overflow flag. It sits between the coprocessor's operand registers and its result bus.

Parameters:
DATA_W, 8, signed element and scalar width in bits
DIM, 5, matrix is DIM x DIM; N = DIM*DIM elements
LANES, 5, elements multiplied per clock; 1 <= LANES <= N

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when busy=0
matriz_A  input  N*DATA_W  operand matrix; element i at bits [i*DATA_W +: DATA_W], signed
num_inteiro  input  DATA_W  signed scalar
sat_mode  input  1  1 = saturate, 0 = wrap (truncate to DATA_W)
nova_matriz_A  output  N*DATA_W  result matrix, same packing as matriz_A
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result complete
overflow  output  1  sticky: at least one product exceeded DATA_W signed range in the last operation

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. On reset: state IDLE, group counter 0, busy=0, done=0, overflow=0, nova_matriz_A=0.
- BEATS = ceil(N/LANES). Group g covers elements g*LANES .. min(g*LANES+LANES, N)-1. Lanes past N in the final group are ignored and write nothing.
- States:
  - IDLE -> RUN on start=1. The same edge captures matriz_A, num_inteiro and sat_mode into working registers, clears overflow and counter, and sets busy=1.
  - RUN: each edge writes group[counter] into nova_matriz_A, ORs that group's overflow bits into overflow, and increments counter. On the edge writing group BEATS-1: go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+BEATS (5 cycles for the defaults). busy is high from edge k through edge k+BEATS.
- Inputs may change freely after capture. The operation uses only the captured copies.
- start while busy=1 is ignored, with no queueing. start in the cycle where done=1 is accepted (back-to-back operations, 0 idle cycles).
- nova_matriz_A is updated in place one group per beat. It is valid only while busy=0 and holds the last result until the next operation begins overwriting it.
- Arithmetic:
  - Full product is 2*DATA_W signed.
  - Out-of-range means the product is > 2^(DATA_W-1)-1 or < -2^(DATA_W-1).
  - sat_mode=1 clamps to max/min. sat_mode=0 keeps the low DATA_W bits, which matches the legacy block bit-for-bit.
  - The overflow bit is raised in both modes.
- Reset mid-operation aborts immediately. All outputs take reset values and no done pulse is issued.

Decomposition:
- Shared package (matriz_pkg): state enum {IDLE, RUN}; functions n_elem(DIM) and beats(N, LANES); function sat_trunc(product, mode) returning the DATA_W result and the overflow bit.
- Sub-module mult_sat_elemento: combinational, one lane (elemento, num, sat_mode -> resultado, ovf). It is instantiated LANES times in a generate loop. The top holds the FSM, counter, captured operands and result register.

Test Plan:
- Defaults, all elements 3, scalar 4, sat_mode=1, start pulse -> all elements 12, overflow=0, done exactly 5 cycles after start, busy high 5 cycles.
- Element[0]=100, scalar 2 -> sat_mode=1 gives 127 with overflow=1; sat_mode=0 gives 0xC8 (-56) with overflow=1. Other elements 1 -> result 2.
- Element[24]=-128, scalar -1 -> sat_mode=1 gives 127; sat_mode=0 gives -128. overflow=1 in both; element[0]=-5 gives 5.
- Assert start again 2 cycles into an operation -> ignored, single done. Assert start in the done cycle -> second operation runs, second done 5 cycles later. Change matriz_A mid-run -> result reflects the captured value.
- Reset on beat 2 -> next cycle busy=0, done=0, overflow=0, result all 0, no done pulse. A following start completes normally.
- LANES=7, DIM=5 -> BEATS=4, final group writes elements 21-24 only, done 4 cycles after start. LANES=1 -> 25 cycles. LANES=25 -> 1 cycle. All match a reference model.
